// File: rtl/smi_flit_pkg.sv
// Shared SMI flit helpers: EOFC width, default EOFC mask, last detection and lane byte offset.
package smi_flit_pkg;

   localparam int EofcWidth = 8;

   function automatic logic [EofcWidth-1:0] eofc_mask_of(input int flit_width);
      return EofcWidth'(2 * flit_width - 1);
   endfunction

   function automatic logic eofc_is_last(input logic [EofcWidth-1:0] eofc);
      return eofc != '0;
   endfunction

   function automatic logic [EofcWidth-1:0] lane_offset(input int lane, input int flit_width);
      return EofcWidth'(lane * flit_width);
   endfunction

endpackage

// File: rtl/smi_flit_scale_up_if.sv
// Narrow-in / wide-out SMI flit bus bundle for the scale-up stage.
interface smi_flit_scale_up_if
   import smi_flit_pkg::*;
#(
   parameter int FlitWidth = 4,
   parameter int ScaleLog2 = 2
);
   localparam int InW  = FlitWidth * 8;
   localparam int OutW = InW * (1 << ScaleLog2);

   logic                 smiInReady;
   logic [EofcWidth-1:0] smiInEofc;
   logic [InW-1:0]       smiInData;
   logic                 smiInStop;
   logic                 smiOutReady;
   logic [EofcWidth-1:0] smiOutEofc;
   logic [OutW-1:0]      smiOutData;
   logic                 smiOutStop;

   // Scale-up block side
   modport slave (
      input  smiInReady, smiInEofc, smiInData, smiOutStop,
      output smiInStop, smiOutReady, smiOutEofc, smiOutData
   );

   // Producer/consumer side
   modport master (
      output smiInReady, smiInEofc, smiInData, smiOutStop,
      input  smiInStop, smiOutReady, smiOutEofc, smiOutData
   );

endinterface

// File: rtl/smi_flit_in_stage.sv
// Input register slice for SMI flits: captures data and masked EOFC, flags last, and backpressures on halt.
module smi_flit_in_stage
   import smi_flit_pkg::*;
#(
   parameter int                   FlitWidth = 4,
   parameter logic [EofcWidth-1:0] EofcMask  = eofc_mask_of(FlitWidth)
) (
   input  logic                   clk,
   input  logic                   arstn,
   input  logic                   in_ready_i,
   input  logic [EofcWidth-1:0]   in_eofc_i,
   input  logic [FlitWidth*8-1:0] in_data_i,
   input  logic                   halt_i,
   output logic                   in_stop_o,
   output logic                   valid_o,
   output logic                   last_o,
   output logic [EofcWidth-1:0]   eofc_o,
   output logic [FlitWidth*8-1:0] data_o
);

   logic                   valid_q, valid_d;
   logic                   last_q;
   logic [EofcWidth-1:0]   eofc_q;
   logic [FlitWidth*8-1:0] data_q;
   logic                   load;
   logic                   accept;
   logic [EofcWidth-1:0]   eofc_masked;

   // An empty register may still fill while downstream is halted
   assign in_stop_o   = valid_q & halt_i;
   assign load        = ~in_stop_o;
   assign accept      = in_ready_i & load;
   assign eofc_masked = in_eofc_i & EofcMask;

   always_comb begin
      valid_d = valid_q;
      if (load) begin
         valid_d = in_ready_i;
      end
   end

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         valid_q <= 1'b0;
      end else begin
         valid_q <= valid_d;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         data_q <= in_data_i;
         eofc_q <= eofc_masked;
         last_q <= eofc_is_last(eofc_masked);
      end
   end

   assign valid_o = valid_q;
   assign last_o  = last_q;
   assign eofc_o  = eofc_q;
   assign data_o  = data_q;

endmodule

// File: rtl/smi_flit_scale_up.sv
// Packs 2^ScaleLog2 narrow SMI flits (low lane first) into one wide flit, closing early on end of frame.
// Define SMI_FLIT_SCALE_ZERO_FILL_EN to zero the unused upper lanes of a short final group.
module smi_flit_scale_up
   import smi_flit_pkg::*;
#(
   parameter int                   FlitWidth = 4,
   parameter int                   ScaleLog2 = 2,
   parameter logic [EofcWidth-1:0] EofcMask  = eofc_mask_of(FlitWidth)
) (
   input logic                 clk,
   input logic                 arstn,
   smi_flit_scale_up_if.slave  smi
);

   localparam int ScaleFactor = 1 << ScaleLog2;
   localparam int InW         = FlitWidth * 8;

   logic                 halt;
   logic                 in_valid;
   logic                 in_last;
   logic [EofcWidth-1:0] in_eofc;
   logic [InW-1:0]       in_data;

   logic [ScaleLog2-1:0] lane_q, lane_d;
   logic                 out_valid_q, out_valid_d;
   logic [EofcWidth-1:0] out_eofc_q, out_eofc_d;
   logic                 advance;
   logic                 lane_full;
   logic [InW*ScaleFactor-1:0] out_data;

   assign halt      = out_valid_q & smi.smiOutStop;
   assign advance   = ~halt & in_valid;
   assign lane_full = (lane_q == ScaleLog2'(ScaleFactor - 1));

   smi_flit_in_stage #(
      .FlitWidth (FlitWidth),
      .EofcMask  (EofcMask)
   ) u_in_stage (
      .clk        (clk),
      .arstn      (arstn),
      .in_ready_i (smi.smiInReady),
      .in_eofc_i  (smi.smiInEofc),
      .in_data_i  (smi.smiInData),
      .halt_i     (halt),
      .in_stop_o  (smi.smiInStop),
      .valid_o    (in_valid),
      .last_o     (in_last),
      .eofc_o     (in_eofc),
      .data_o     (in_data)
   );

   always_comb begin
      lane_d      = lane_q;
      out_valid_d = out_valid_q;
      out_eofc_d  = out_eofc_q;
      if (!halt) begin
         out_valid_d = 1'b0;
         if (in_valid) begin
            if (in_last || lane_full) begin
               out_valid_d = 1'b1;
               lane_d      = '0;
               out_eofc_d  = in_last ? lane_offset(int'(lane_q), FlitWidth) + in_eofc : '0;
            end else begin
               lane_d = lane_q + ScaleLog2'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         lane_q      <= '0;
         out_valid_q <= 1'b0;
         out_eofc_q  <= '0;
      end else begin
         lane_q      <= lane_d;
         out_valid_q <= out_valid_d;
         out_eofc_q  <= out_eofc_d;
      end
   end

   // The departing flit is accepted on the same edge a new lane-0 write lands, so sharing is safe
   for (genvar gi = 0; gi < ScaleFactor; gi++) begin : g_lane
      logic [InW-1:0] lane_data_q;
      logic           wr_en;
      assign wr_en = advance && (lane_q == ScaleLog2'(gi));
`ifdef SMI_FLIT_SCALE_ZERO_FILL_EN
      logic clr_en;
      assign clr_en = advance && in_last && (int'(lane_q) < gi);
      always_ff @(posedge clk) begin
         if (wr_en) begin
            lane_data_q <= in_data;
         end else if (clr_en) begin
            lane_data_q <= '0;
         end
      end
`else
      always_ff @(posedge clk) begin
         if (wr_en) begin
            lane_data_q <= in_data;
         end
      end
`endif
      assign out_data[gi*InW +: InW] = lane_data_q;
   end

   assign smi.smiOutReady = out_valid_q;
   assign smi.smiOutEofc  = out_eofc_q;
   assign smi.smiOutData  = out_data;

endmodule

// File: tb/tb_smi_flit_scale_up.sv
// Scoreboard bench for smi_flit_scale_up: frame-level reference model feeds an expected queue, a monitor checks outputs.
module tb_smi_flit_scale_up;

   localparam int FW = 4;
   localparam int SL = 2;
   localparam int SF = 1 << SL;
   localparam int IW = FW * 8;
   localparam int OW = IW * SF;
   localparam logic [7:0] EMASK = 8'(2 * FW - 1);
`ifdef SMI_FLIT_SCALE_ZERO_FILL_EN
   localparam bit ZF = 1'b1;
`else
   localparam bit ZF = 1'b0;
`endif

   logic clk = 1'b0;
   logic arstn = 1'b0;
   always #5 clk = ~clk;

   smi_flit_scale_up_if #(.FlitWidth(FW), .ScaleLog2(SL)) bus ();

   smi_flit_scale_up #(.FlitWidth(FW), .ScaleLog2(SL)) dut (
      .clk   (clk),
      .arstn (arstn),
      .smi   (bus)
   );

   int errors = 0;
   int checks = 0;
   int stop_mode = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: frame-level packing rules over a lane image
   logic [IW-1:0] m_mem [SF];
   bit            m_known [SF];
   int            m_lane = 0;
   logic [OW-1:0] q_data [$];
   logic [7:0]    q_eofc [$];
   logic [SF-1:0] q_known [$];
   logic [IW-1:0] sent_d [16];

   function automatic void model_push(input logic [IW-1:0] d, input logic [7:0] e);
      logic [7:0]    me;
      logic [OW-1:0] od;
      logic [SF-1:0] km;
      me = e & EMASK;
      m_mem[m_lane]   = d;
      m_known[m_lane] = 1'b1;
      if (me != 0 || m_lane == SF - 1) begin
         if (me != 0 && ZF) begin
            for (int k = m_lane + 1; k < SF; k++) begin
               m_mem[k]   = '0;
               m_known[k] = 1'b1;
            end
         end
         for (int k = 0; k < SF; k++) begin
            od[k*IW +: IW] = m_mem[k];
            km[k]          = m_known[k];
         end
         q_data.push_back(od);
         q_eofc.push_back(me != 0 ? 8'(m_lane * FW) + me : 8'd0);
         q_known.push_back(km);
         m_lane = 0;
      end else begin
         m_lane++;
      end
   endfunction

   function automatic void model_reset();
      m_lane = 0;
      for (int k = 0; k < SF; k++) m_known[k] = 1'b0;
      q_data.delete();
      q_eofc.delete();
      q_known.delete();
   endfunction

   // Output stop driver
   initial begin
      bus.smiOutStop = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (stop_mode)
            0:       bus.smiOutStop = 1'b0;
            2:       bus.smiOutStop = 1'b1;
            default: bus.smiOutStop = ($urandom_range(0, 2) == 0);
         endcase
      end
   end

   // Monitor / scoreboard
   logic          held = 1'b0;
   logic [OW-1:0] held_d;
   logic [7:0]    held_e;
   logic [OW-1:0] mon_exp, mon_mask;
   logic [SF-1:0] mon_km;
   logic [7:0]    mon_e;
   int            out_count = 0;

   initial begin
      forever begin
         @(negedge clk);
         if (!arstn) begin
            held = 1'b0;
         end else begin
            if (held) begin
               check("hold_ready", bus.smiOutReady, 1'b1);
               check("hold_data", bus.smiOutData, held_d);
               check("hold_eofc", bus.smiOutEofc, held_e);
            end
            held = 1'b0;
            if (bus.smiInStop) check("instop_needs_halt", bus.smiOutReady & bus.smiOutStop, 1'b1);
            if (bus.smiOutReady) begin
               if (bus.smiOutStop) begin
                  held   = 1'b1;
                  held_d = bus.smiOutData;
                  held_e = bus.smiOutEofc;
               end else if (q_data.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_out: got eofc %0h data %0h expected none", bus.smiOutEofc, bus.smiOutData);
               end else begin
                  mon_exp = q_data.pop_front();
                  mon_e   = q_eofc.pop_front();
                  mon_km  = q_known.pop_front();
                  for (int k = 0; k < SF; k++) mon_mask[k*IW +: IW] = mon_km[k] ? '1 : '0;
                  check("out_eofc", bus.smiOutEofc, mon_e);
                  check("out_data", bus.smiOutData & mon_mask, mon_exp & mon_mask);
                  $display("out #%0d eofc=%0d data=%h", out_count, bus.smiOutEofc, bus.smiOutData);
                  out_count++;
               end
            end
         end
      end
   end

   // Called just after a rising edge; returns just after the edge that accepted the flit
   task automatic send_flit(input logic [IW-1:0] d, input logic [7:0] e);
      int guard;
      guard = 0;
      bus.smiInReady = 1'b1;
      bus.smiInData  = d;
      bus.smiInEofc  = e;
      @(negedge clk);
      while (bus.smiInStop && guard < 200) begin
         guard++;
         @(negedge clk);
      end
      if (guard >= 200) begin
         checks++;
         errors++;
         $display("FAIL in_stop_timeout: got stop stuck high expected release within 200 cycles");
      end
      model_push(d, e);
      @(posedge clk);
      #1;
      bus.smiInReady = 1'b0;
   endtask

   task automatic send_frame(input int n, input logic [7:0] last_e, input int max_gap);
      logic [IW-1:0] d;
      for (int i = 0; i < n; i++) begin
         d = IW'($urandom);
         if (i < 16) sent_d[i] = d;
         send_flit(d, (i == n - 1) ? last_e : 8'd0);
         if (max_gap > 0) begin
            repeat ($urandom_range(0, max_gap)) begin
               @(posedge clk);
               #1;
            end
         end
      end
   endtask

   task automatic drain();
      int g;
      g = 0;
      while (q_data.size() != 0 && g < 2000) begin
         @(negedge clk);
         g++;
      end
      if (q_data.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d pending outputs expected 0", q_data.size());
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int g;
      bus.smiInReady = 1'b0;
      bus.smiInEofc  = '0;
      bus.smiInData  = '0;
      model_reset();
      arstn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_ready", bus.smiOutReady, 1'b0);
      check("rst_in_stop", bus.smiInStop, 1'b0);
      check("rst_out_eofc", bus.smiOutEofc, 8'd0);
      @(negedge clk);
      arstn = 1'b1;
      @(posedge clk);
      #1;

      // Full group: latency and packing
      send_frame(4, 8'd4, 0);
      check("lat_not_yet", bus.smiOutReady, 1'b0);
      @(posedge clk);
      #1;
      check("lat_valid", bus.smiOutReady, 1'b1);
      check("t1_eofc", bus.smiOutEofc, 8'd16);
      check("t1_data", bus.smiOutData, {sent_d[3], sent_d[2], sent_d[1], sent_d[0]});
      drain();

      // Six-flit frame, short last group
      send_frame(6, 8'd2, 0);
      drain();

      // Single-flit frame
      send_frame(1, 8'd3, 1);
      drain();

      // Masked EOFC 0xF9 at a random lane
      send_frame($urandom_range(1, 4), 8'hF9, 1);
      drain();

      // Held output stop while input streams
      stop_mode = 2;
      fork
         send_frame(8, 8'd4, 0);
         begin
            g = 0;
            while (!bus.smiOutReady && g < 100) begin
               @(negedge clk);
               g++;
            end
            repeat (5) @(negedge clk);
            check("stall_out_ready", bus.smiOutReady, 1'b1);
            check("stall_in_stop", bus.smiInStop, 1'b1);
            stop_mode = 0;
         end
      join
      drain();

      // Reset in the middle of a group
      send_frame(2, 8'd0, 0);
      repeat (2) @(posedge clk);
      #3;
      arstn = 1'b0;
      #1;
      check("mid_rst_ready", bus.smiOutReady, 1'b0);
      check("mid_rst_eofc", bus.smiOutEofc, 8'd0);
      check("mid_rst_in_stop", bus.smiInStop, 1'b0);
      model_reset();
      @(negedge clk);
      arstn = 1'b1;
      @(posedge clk);
      #1;
      send_frame(4, 8'd4, 0);
      drain();

      // Random frames with random output stop
      stop_mode = 1;
      for (int f = 0; f < 40; f++) begin
         send_frame($urandom_range(1, 9), {5'($urandom), 3'($urandom_range(1, FW))}, 2);
      end
      stop_mode = 0;
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
